fifo_packed_bytes: RTL
======================

Name: fifo_packed_bytes

Overview:
Parametrised byte-serialising FIFO for the UART transmit path. It accepts 1..MAX_BYTES bytes per cycle as one variable-width write and presents them one byte at a time to the transmitter under a valid/ack handshake. It generalises the fixed 4-byte interleaved FIFO with:
- configurable depth and write width
- selectable byte order
- all-or-nothing space check
- level/full/empty status
- a sticky overflow flag

Parameters:
DEPTH_BYTES, 16, byte capacity; power of two, >= MAX_BYTES
MAX_BYTES, 4, maximum bytes per write; write_data is MAX_BYTES*8 bits
MSB_FIRST, 1, 1: write_data[8*W-1 -: 8] is emitted first; 0: write_data[7:0] is emitted first

Ports:
clk_i  input  1  clock
reset_i  input  1  asynchronous active-high reset
write_enable  input  1  write request
write_data  input  MAX_BYTES*8  packed bytes; only the low W = write_width bytes are meaningful
write_width  input  $clog2(MAX_BYTES)+1  byte count W, 0..MAX_BYTES
write_accept  output  1  combinational; request is taken at this clock edge
ack  input  1  consumer pops the current byte
read_data  output  8  current head byte
read_valid  output  1  head byte present
level  output  $clog2(DEPTH_BYTES)+1  bytes stored
full  output  1  level == DEPTH_BYTES
empty  output  1  level == 0
overflow  output  1  sticky: a non-zero write was rejected
clear_overflow  input  1  synchronous clear of overflow

Behaviour:
- Reset values, applied asynchronously while reset_i is high: pointers 0, level 0, empty 1, full 0, read_valid 0, overflow 0. Memory is not reset.
- read_data is forced to 0 whenever empty.
- Storage is a circular byte array with rd_ptr/wr_ptr of $clog2(DEPTH_BYTES)+1 bits. Wrap is by natural overflow; the MSB distinguishes full from empty.
- write_accept = write_enable && W != 0 && W <= MAX_BYTES && W <= (DEPTH_BYTES - level).
- The space check uses the pre-edge level. A same-cycle pop does not free space for that cycle's write.
- On accept:
  - the W bytes are stored at wr_ptr .. wr_ptr+W-1 (mod depth), in emission order set by MSB_FIRST;
  - wr_ptr advances by W.
- Writes that wrap the array boundary are legal and split transparently.
- Rejection is all-or-nothing: no partial writes.
- write_enable with W=0: no-op, no overflow.
- write_enable with W > MAX_BYTES, or with insufficient space: rejected, overflow set at that edge.
- read_valid = !empty. read_data = mem[rd_ptr]. There is no output register.
- Latency: a byte accepted at edge N is visible at read_data/read_valid immediately after edge N.
- ack with read_valid: rd_ptr and level move by one at the edge. ack while empty is ignored.
- A byte written into an empty FIFO cannot be popped in the same cycle.
- Simultaneous accept and pop: level_next = level + W - 1.
- clear_overflow and a new overflow event in the same cycle: overflow stays 1 (set wins).
- reset_i asserted mid-stream discards all contents in the same cycle. No handshake completes at that edge.
- No FSM beyond the pointer/level registers. level is registered, not derived combinationally from the pointers.

Optional Feature:
Macro FIFO_PACKED_FLUSH_EN.
- With the macro defined:
  - adds input flush (1 bit);
  - flush at an edge sets rd_ptr <= wr_ptr_next and level <= 0; an accept in the same cycle is also discarded (flush wins);
  - overflow is unaffected.
- Without the macro: the port does not exist and contents drain only via ack or reset.

Decomposition:
- config_pkg holds FifoEntryWidthBits (= MAX_BYTES*8), FifoEntryWidthSize (= $clog2(MAX_BYTES)), FifoDepthBytes, FifoMsbFirst as the defaults.
- decoder_pkg is unchanged.
- One sub-module, fifo_byte_ram: DEPTH_BYTES x 8 memory with:
  - a MAX_BYTES-lane write port, each lane with its own address and enable;
  - one asynchronous read port.
- The parent contains pointer/level/flag logic and the lane byte-order mux.

Test Plan:
1. Reset, then write 0xDEADBEEF W=4 (MSB_FIRST=1), ack four times → read_data DE, AD, BE, EF; then empty=1, read_data=0, level 0.
2. Fill 16 bytes with four W=4 writes → full=1. Write 0x12345678 W=4 → write_accept=0, overflow=1, level stays 16. clear_overflow → overflow=0.
3. Fill 14 bytes, drain 14, write 0x11223344 W=4 → pointers wrap. Drain order 11,22,33,44 is correct across the boundary.
4. level=15, write W=2 with simultaneous ack → rejected (pre-edge space 1), overflow=1, level=14.
5. MSB_FIRST=0, write 0xAABBCC W=3 → emits CC, BB, AA. A W=0 write gives no change and no overflow. A W=5 write is rejected with overflow=1.
6. Assert reset_i asynchronously mid-drain (level 7) → read_valid, level, overflow go 0 before the next clk_i edge. With FIFO_PACKED_FLUSH_EN: flush plus a W=4 write at level 5 → level 0, empty 1.

Source files
------------

// File: rtl/fifo_packed_bytes_pkg.sv
// Shared defaults and byte-lane helper for the packed-byte UART transmit FIFO.
package fifo_packed_bytes_pkg;

  localparam int FifoEntryWidthBits = 32;
  localparam int FifoEntryWidthSize = $clog2(FifoEntryWidthBits / 8);
  localparam int FifoDepthBytes     = 16;
  localparam bit FifoMsbFirst       = 1'b1;

  // Byte position in write_data that becomes the lane-th emitted byte of a width-byte write.
  function automatic int lane_src(input bit msb_first, input int width, input int lane);
    return msb_first ? (width - 1 - lane) : lane;
  endfunction

endpackage

// File: rtl/fifo_packed_bytes_byte_ram.sv
// DEPTH x 8 byte memory: LANES independent write lanes, one asynchronous read port.
module fifo_byte_ram #(
  parameter  int DEPTH = 16,
  parameter  int LANES = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                       clk_i,
  input  logic [LANES-1:0]           we_i,
  input  logic [LANES-1:0][AW-1:0]   waddr_i,
  input  logic [LANES-1:0][7:0]      wdata_i,
  input  logic [AW-1:0]              raddr_i,
  output logic [7:0]                 rdata_o
);

  logic [7:0] mem_q [DEPTH];

  // Lane addresses are consecutive and never exceed DEPTH, so lanes never collide.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < LANES; i++) begin
      if (we_i[i]) mem_q[waddr_i[i]] <= wdata_i[i];
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fifo_packed_bytes.sv
// Byte-serialising FIFO: variable-width packed writes in, one byte per ack out.
// Optional flush input enabled by defining FIFO_PACKED_FLUSH_EN.
module fifo_packed_bytes
  import fifo_packed_bytes_pkg::*;
#(
  parameter  int DEPTH_BYTES = FifoDepthBytes,
  parameter  int MAX_BYTES   = FifoEntryWidthBits / 8,
  parameter  bit MSB_FIRST   = FifoMsbFirst,
  localparam int AW          = $clog2(DEPTH_BYTES),
  localparam int PW          = AW + 1,
  localparam int WW          = $clog2(MAX_BYTES) + 1
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   write_enable,
  input  logic [MAX_BYTES*8-1:0] write_data,
  input  logic [WW-1:0]          write_width,
  output logic                   write_accept,
  input  logic                   ack,
  output logic [7:0]             read_data,
  output logic                   read_valid,
  output logic [PW-1:0]          level,
  output logic                   full,
  output logic                   empty,
  output logic                   overflow,
`ifdef FIFO_PACKED_FLUSH_EN
  input  logic                   flush,
`endif
  input  logic                   clear_overflow
);

  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] level_q, level_d;
  logic          overflow_q, overflow_d;

  logic [PW:0]   space;
  logic          w_nonzero, w_legal, reject, pop;
  logic [PW-1:0] w_add;

  logic [MAX_BYTES-1:0]          lane_we;
  logic [MAX_BYTES-1:0][AW-1:0]  lane_addr;
  logic [MAX_BYTES-1:0][7:0]     lane_data;
  logic [7:0]                    ram_rdata;

  // Space is judged on the pre-edge level; a concurrent pop frees nothing this cycle.
  assign space        = (PW+1)'(DEPTH_BYTES) - {1'b0, level_q};
  assign w_nonzero    = write_width != '0;
  assign w_legal      = write_width <= WW'(MAX_BYTES);
  assign write_accept = write_enable && w_nonzero && w_legal &&
                        ((PW+1)'(write_width) <= space);
  assign reject       = write_enable && w_nonzero && !write_accept;
  assign pop          = ack && !empty;
  assign w_add        = write_accept ? PW'(write_width) : '0;

  always_comb begin
    int src;
    src       = 0;
    lane_we   = '0;
    lane_addr = '0;
    lane_data = '0;
    for (int i = 0; i < MAX_BYTES; i++) begin
      lane_addr[i] = wr_ptr_q[AW-1:0] + AW'(i);
      if (write_accept && (i < int'(write_width))) begin
        lane_we[i] = 1'b1;
        src        = lane_src(MSB_FIRST, int'(write_width), i);
        for (int j = 0; j < MAX_BYTES; j++) begin
          if (j == src) lane_data[i] = write_data[8*j +: 8];
        end
      end
    end
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q + w_add;
    rd_ptr_d   = rd_ptr_q + PW'(pop);
    level_d    = level_q + w_add - PW'(pop);
    overflow_d = reject ? 1'b1 : (clear_overflow ? 1'b0 : overflow_q);
`ifdef FIFO_PACKED_FLUSH_EN
    // Jumping the read pointer past the new write discards it along with the old contents.
    if (flush) begin
      rd_ptr_d = wr_ptr_d;
      level_d  = '0;
    end
`endif
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
    end
  end

  fifo_byte_ram #(
    .DEPTH (DEPTH_BYTES),
    .LANES (MAX_BYTES)
  ) u_ram (
    .clk_i   (clk_i),
    .we_i    (lane_we),
    .waddr_i (lane_addr),
    .wdata_i (lane_data),
    .raddr_i (rd_ptr_q[AW-1:0]),
    .rdata_o (ram_rdata)
  );

  assign level      = level_q;
  assign empty      = level_q == '0;
  assign full       = level_q == PW'(DEPTH_BYTES);
  assign overflow   = overflow_q;
  assign read_valid = !empty;
  assign read_data  = empty ? 8'h00 : ram_rdata;

endmodule
